instr_fetch_unit: RTL

// - Front end of the 16-bit CPU: owns the PC, fetches 16-bit instructions from instruction memory, buffers them
//   and hands them to the Datapath/CU decode stage over a valid/ready handshake.
// - Accepts branch/jump redirects from the Datapath, flushing buffered and in-flight fetches.
// - Replaces the free-running PC inside the Datapath; the decode stage stalls the fetcher through InstrReady.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/instr_fetch_unit_fifo.sv | 62 ++++++
 rtl/instr_fetch_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU front end.
//   INSTR_W / ADDR_W : instruction word and byte-address widths
//   OPCODE_W / OPCODE_MSB : location of the opcode field consumed by the CU
//   fetch_state_t : fetch sequencer states
package cpu_pkg;

    localparam int INSTR_W    = 16;
    localparam int ADDR_W     = 16;
    localparam int OPCODE_W   = 4;
    localparam int OPCODE_MSB = 15;

    // IDLE: no request outstanding
    // WAIT: request outstanding, its data will be kept
    // DROP: request outstanding, its data will be discarded (redirect happened)
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } fetch_state_t;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPCODE_MSB -: OPCODE_W];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_fifo: synchronous prefetch buffer between the instruction memory
// interface and the decode stage.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push/wdata : write one entry (ignored when full or flushing)
//   pop        : retire the head entry (ignored when empty)
//   flush      : synchronous clear, wins over push and pop
//   rdata      : head entry, forced to zero while empty
//   empty      : no entries held
//   count      : number of entries held
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign push_ok = push & (count != DEPTH_C);
    assign pop_ok  = pop & ~empty;
    // Zero while empty so the decode-side outputs read 0 after reset
    // without having to reset the storage itself.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: CPU front end. Owns the PC, issues fetches to
// instruction memory, buffers returned words and presents them to decode.
//   Clock, Reset_n         : clock, asynchronous active-low reset
//   ImemReq/ImemAddr       : registered fetch request, held until ImemAck
//   ImemAck/ImemData       : memory accepts request, data valid same cycle
//   Redirect/RedirectPC    : taken branch/jump, flushes buffered and in-flight fetches
//   InstrValid/Instr/InstrPC : head of the prefetch buffer
//   InstrReady             : decode consumes the head this cycle
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = 16'h0000,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic               Clock,
    input  logic               Reset_n,
    output logic               ImemReq,
    output logic [ADDR_W-1:0]  ImemAddr,
    input  logic               ImemAck,
    input  logic [INSTR_W-1:0] ImemData,
    input  logic               Redirect,
    input  logic [ADDR_W-1:0]  RedirectPC,
    output logic               InstrValid,
    output logic [INSTR_W-1:0] Instr,
    output logic [ADDR_W-1:0]  InstrPC,
    input  logic               InstrReady
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]     DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-1){1'b1}}, 1'b0};
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(2);

    fetch_state_t                 state_q;
    fetch_state_t                 state_d;
    logic [ADDR_W-1:0]            pc_q;
    logic [ADDR_W-1:0]            pc_d;
    logic                         req_d;
    logic [ADDR_W-1:0]            addr_d;
    logic [ADDR_W-1:0]            redirect_tgt;
    logic [CW-1:0]                count;
    logic [CW-1:0]                count_after;
    logic                         fifo_empty;
    logic                         push;
    logic                         pop;
    logic [ADDR_W+INSTR_W-1:0]    head;

    assign redirect_tgt = RedirectPC & ALIGN_MASK;
    assign pop          = InstrValid & InstrReady;
    // A redirect in the ack cycle turns the returning word into a wrong-path fetch.
    assign push         = (state_q == WAIT) & ImemAck & ~Redirect;
    assign count_after  = count + CW'(push) - CW'(pop);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = ImemReq;
        addr_d  = ImemAddr;
        case (state_q)
            IDLE: begin
                if (Redirect) begin
                    pc_d = redirect_tgt;
                end else if (count < DEPTH_C) begin
                    state_d = WAIT;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
            end
            WAIT: begin
                if (Redirect && ImemAck) begin
                    pc_d    = redirect_tgt;
                    state_d = IDLE;
                    req_d   = 1'b0;
                end else if (Redirect) begin
                    // The outstanding request cannot be withdrawn; let it finish and discard it.
                    pc_d    = redirect_tgt;
                    state_d = DROP;
                end else if (ImemAck) begin
                    pc_d = ImemAddr + PC_STEP;
                    if (count_after < DEPTH_C) begin
                        addr_d = ImemAddr + PC_STEP;
                    end else begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end
            end
            DROP: begin
                if (Redirect) pc_d = redirect_tgt;
                if (ImemAck) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            ImemReq  <= 1'b0;
            ImemAddr <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ImemReq  <= req_d;
            ImemAddr <= addr_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ADDR_W + INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (Clock),
        .rst_n (Reset_n),
        .push  (push),
        .wdata ({ImemAddr, ImemData}),
        .pop   (pop),
        .flush (Redirect),
        .rdata (head),
        .empty (fifo_empty),
        .count (count)
    );

    assign InstrValid = ~fifo_empty;
    assign InstrPC    = head[ADDR_W+INSTR_W-1:INSTR_W];
    assign Instr      = head[INSTR_W-1:0];

endmodule
